// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode/divider encodings, controller states and
// the divider-select to half-period mapping.
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam logic [1:0] CLOCK2  = 2'b00;
  localparam logic [1:0] CLOCK4  = 2'b01;
  localparam logic [1:0] CLOCK8  = 2'b10;
  localparam logic [1:0] CLOCK16 = 2'b11;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  // Half SCLK period in sys_clock cycles.
  function automatic logic [3:0] half_period(input logic [1:0] speed);
    logic [3:0] h;
    h = 4'd1;
    case (speed)
      CLOCK2:  h = 4'd1;
      CLOCK4:  h = 4'd2;
      CLOCK8:  h = 4'd4;
      CLOCK16: h = 4'd8;
      default: h = 4'd1;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// Half-period tick generator: one-cycle tick every H cycles while enabled.
// The count restarts from zero whenever enable drops.
module spi_edge_gen
  import spi_pkg::*;
(
  input  logic       sys_clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] speed,
  output logic       tick
);

  logic [3:0] cnt;
  logic [3:0] half;

  assign half = half_period(speed);
  assign tick = enable && (cnt == half - 4'd1);

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 4'd0;
    end else if (!enable || tick) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transaction controller: start/busy/done host handshake, SCLK
// sequencing at the latched divide ratio, MSB-first shift in both directions.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        clock_mode,
  input  logic [1:0]        clock_speed,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ss_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [4:0] LAST_EDGE = 5'(2 * DATA_W);

  state_t            state;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [4:0]        edge_cnt;
  logic [4:0]        edge_nxt;
  logic              cpha;
  logic [1:0]        speed;
  logic              tick;
  logic              gen_en;
  logic              sclk_edge;
  logic              leading;

  assign gen_en    = (state == SETUP) || (state == XFER) || (state == HOLD);
  assign edge_nxt  = edge_cnt + 5'd1;
  assign leading   = edge_nxt[0];
  // The SETUP-ending tick is itself SCLK edge 1; the tick after the last edge only leaves XFER.
  assign sclk_edge = tick && ((state == SETUP) || ((state == XFER) && (edge_cnt != LAST_EDGE)));

  spi_edge_gen u_edge_gen (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .enable    (gen_en),
    .speed     (speed),
    .tick      (tick)
  );

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ss_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      edge_cnt <= 5'd0;
      tx_shift <= '0;
      rx_shift <= '0;
      cpha     <= 1'b0;
      speed    <= CLOCK2;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          sclk <= clock_mode[1];
          if (start) begin
            state    <= SETUP;
            ss_n     <= 1'b0;
            busy     <= 1'b1;
            tx_shift <= tx_data;
            cpha     <= clock_mode[0];
            speed    <= clock_speed;
            edge_cnt <= 5'd0;
            mosi     <= clock_mode[0] ? 1'b0 : tx_data[DATA_W-1];
          end else begin
            state <= IDLE;
            ss_n  <= 1'b1;
            mosi  <= 1'b0;
          end
        end
        SETUP: if (tick) state <= XFER;
        XFER:  if (tick && (edge_cnt == LAST_EDGE)) state <= HOLD;
        HOLD: begin
          if (tick) begin
            state   <= DONE;
            done    <= 1'b1;
            ss_n    <= 1'b1;
            busy    <= 1'b0;
            rx_data <= rx_shift;
          end
        end
        default: state <= IDLE;
      endcase

      if (sclk_edge) begin
        edge_cnt <= edge_nxt;
        sclk     <= ~sclk;
        if (leading == cpha) begin
          // Launch edge: CPHA=1 drives on leading, CPHA=0 on trailing (not after the final edge).
          if (cpha || (edge_nxt != LAST_EDGE)) begin
            mosi     <= cpha ? tx_shift[DATA_W-1] : tx_shift[DATA_W-2];
            tx_shift <= tx_shift << 1;
          end
        end else begin
          rx_shift <= {rx_shift[DATA_W-2:0], miso};
        end
      end
    end
  end

endmodule
